// File: rtl/sram_arbiter_2port_if.sv
// Requester-side handshake bundle for one client of the shared SRAM.
// The client drives req/we/addr/wdata and sees ack/rdata coming back.
interface sram_arbiter_2port_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arbiter_2port.sv
// Round-robin arbiter and sequencer for a single-port SRAM shared by two
// requesters. Each transaction runs IDLE -> ACCESS -> ACK, three cycles
// from the granting edge. All control outputs come straight from flops,
// so an asynchronous reset pulls mem_wr_en low before the next edge and
// an interrupted write never reaches the SRAM.
module sram_arbiter_2port #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset_p,
  sram_arbiter_2port_if.slave port_a,
  sram_arbiter_2port_if.slave port_b,
  output logic                mem_wr_en,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  inout  wire  [DATA_W-1:0]   mem_data,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            state;
  logic              owner_b;
  logic              prio_b;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;

  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick the winner for this IDLE edge: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    grant_b   = (port_a.req && port_b.req) ? prio_b : port_b.req;
    sel_we    = grant_b ? port_b.we    : port_a.we;
    sel_addr  = grant_b ? port_b.addr  : port_a.addr;
    sel_wdata = grant_b ? port_b.wdata : port_a.wdata;
  end

  // The data bus is driven only while a write is in its ACCESS cycle; mem_wr_en
  // and mem_rd_en are never set together, so the SRAM and this block never fight.
  assign mem_data = mem_wr_en ? lat_wdata : {DATA_W{1'bz}};

  // Transaction sequencer with registered SRAM controls, acks and read data.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state        <= IDLE;
      owner_b      <= 1'b0;
      prio_b       <= 1'b0;
      lat_we       <= 1'b0;
      lat_wdata    <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      busy         <= 1'b0;
      port_a.ack   <= 1'b0;
      port_b.ack   <= 1'b0;
      port_a.rdata <= '0;
      port_b.rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (port_a.req || port_b.req) begin
            owner_b   <= grant_b;
            lat_we    <= sel_we;
            lat_wdata <= sel_wdata;
            mem_addr  <= sel_addr;
            mem_wr_en <= sel_we;
            mem_rd_en <= !sel_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            if (owner_b) port_b.rdata <= mem_data;
            else         port_a.rdata <= mem_data;
          end
          mem_wr_en  <= 1'b0;
          mem_rd_en  <= 1'b0;
          mem_addr   <= '0;
          port_a.ack <= !owner_b;
          port_b.ack <= owner_b;
          state      <= ACK;
        end
        ACK: begin
          port_a.ack <= 1'b0;
          port_b.ack <= 1'b0;
          busy       <= 1'b0;
          prio_b     <= !owner_b;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_2port.sv
// Bench for sram_arbiter_2port: an SRAM behavioural model on the shared bus,
// a transaction-level reference model checked every cycle, a table of
// directed transactions, hand-written fairness/reset sequences and a
// randomized phase.
module tb_sram_arbiter_2port;
  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 8;
  localparam logic [7:0]  PROBE  = 8'hC3;

  logic        clk = 1'b0;
  logic        reset_p = 1'b0;
  logic        mem_wr_en, mem_rd_en, busy;
  logic [9:0]  mem_addr;
  wire  [7:0]  mem_data;

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter_2port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ia ();
  sram_arbiter_2port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ib ();

  sram_arbiter_2port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .port_a    (ia),
    .port_b    (ib),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus on read, commits on the edge when wr_en is high.
  logic [7:0] sram [1024] = '{default: 8'h00};
  assign mem_data = mem_rd_en ? sram[mem_addr] : 8'bz;
  // Probe pattern on an otherwise idle bus, so any stray drive from the DUT shows up.
  assign mem_data = (!mem_rd_en && !mem_wr_en) ? PROBE : 8'bz;
  always @(posedge clk) if (mem_wr_en) sram[mem_addr] <= mem_data;

  // Reference model: one transaction occupies the cycle after the grant (memory
  // access) and the following cycle (ack); the pointer then favours the other side.
  logic [7:0] ref_mem [1024] = '{default: 8'h00};
  int         m_left = 0;
  logic       m_owner_b = 1'b0, m_we = 1'b0, m_prio_b = 1'b0;
  logic [9:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_rdata_a = '0, m_rdata_b = '0;
  wire        m_pick_b = (ia.req && ib.req) ? m_prio_b : ib.req;

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      m_left <= 0; m_prio_b <= 1'b0; m_owner_b <= 1'b0;
      m_rdata_a <= '0; m_rdata_b <= '0;
    end else if (m_left == 0) begin
      if (ia.req || ib.req) begin
        m_owner_b <= m_pick_b;
        m_we      <= m_pick_b ? ib.we    : ia.we;
        m_addr    <= m_pick_b ? ib.addr  : ia.addr;
        m_wdata   <= m_pick_b ? ib.wdata : ia.wdata;
        m_left    <= 2;
      end
    end else if (m_left == 2) begin
      if (m_we)           ref_mem[m_addr] <= m_wdata;
      else if (m_owner_b) m_rdata_b <= ref_mem[m_addr];
      else                m_rdata_a <= ref_mem[m_addr];
      m_left <= 1;
    end else begin
      m_prio_b <= !m_owner_b;
      m_left   <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare all outputs and the bus against the reference model.
  always @(negedge clk) begin
    logic [7:0] exp_bus;
    exp_bus = (m_left == 2) ? (m_we ? m_wdata : ref_mem[m_addr]) : PROBE;
    checkOutput("busy",    32'(busy),      32'(m_left != 0));
    checkOutput("wr_en",   32'(mem_wr_en), 32'(m_left == 2 && m_we));
    checkOutput("rd_en",   32'(mem_rd_en), 32'(m_left == 2 && !m_we));
    checkOutput("addr",    32'(mem_addr),  (m_left == 2) ? 32'(m_addr) : 32'd0);
    checkOutput("ack_a",   32'(ia.ack),    32'(m_left == 1 && !m_owner_b));
    checkOutput("ack_b",   32'(ib.ack),    32'(m_left == 1 && m_owner_b));
    checkOutput("rdata_a", 32'(ia.rdata),  32'(m_rdata_a));
    checkOutput("rdata_b", 32'(ib.rdata),  32'(m_rdata_b));
    checkOutput("bus",     32'(mem_data),  32'(exp_bus));
  end

  typedef struct {
    logic       req_a; logic we_a; logic [9:0] addr_a; logic [7:0] wdata_a;
    logic       req_b; logic we_b; logic [9:0] addr_b; logic [7:0] wdata_b;
    int         exp_first;
    logic [7:0] exp_rda;
    logic [7:0] exp_rdb;
  } vec_t;

  // Issue the requests of one record, release each on its ack, then check
  // which side was served first and the resulting read data.
  task automatic applyStimulus(input vec_t v);
    bit got_a, got_b;
    int first;
    @(negedge clk);
    ia.req = v.req_a; ia.we = v.we_a; ia.addr = v.addr_a; ia.wdata = v.wdata_a;
    ib.req = v.req_b; ib.we = v.we_b; ib.addr = v.addr_b; ib.wdata = v.wdata_b;
    got_a = !v.req_a; got_b = !v.req_b; first = -1;
    for (int c = 0; c < 20 && !(got_a && got_b); c++) begin
      @(negedge clk);
      if (ia.ack && !got_a) begin got_a = 1'b1; ia.req = 1'b0; if (first < 0) first = 0; end
      if (ib.ack && !got_b) begin got_b = 1'b1; ib.req = 1'b0; if (first < 0) first = 1; end
    end
    ia.req = 1'b0; ib.req = 1'b0;
    checkOutput("vec_acks_seen", 32'(got_a && got_b), 32'd1);
    checkOutput("vec_first_grant", 32'(first), 32'(v.exp_first));
    checkOutput("vec_rdata_a", 32'(ia.rdata), 32'(v.exp_rda));
    checkOutput("vec_rdata_b", 32'(ib.rdata), 32'(v.exp_rdb));
  endtask

  function automatic logic [9:0] pickAddr();
    case ($urandom_range(3, 0))
      0:       return 10'd0;
      1:       return 10'd1023;
      2:       return 10'($urandom_range(7, 0));
      default: return 10'($urandom_range(1023, 0));
    endcase
  endfunction

  vec_t vecs[7];
  vec_t post_reset;

  initial begin
    int acks, last_cyc, cyc;
    int owners[4];
    int cycles[4];

    vecs[0] = '{1'b1, 1'b1, 10'd0,    8'hA5, 1'b0, 1'b0, 10'd0,    8'h00, 0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 10'd0,    8'h00, 1'b0, 1'b0, 10'd0,    8'h00, 0, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 1'b1, 10'd1023, 8'h3C, 1, 8'hA5, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b0, 1'b0, 10'd0,    8'h00, 0, 8'h3C, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 10'd5,    8'h77, 1'b1, 1'b0, 10'd0,    8'h00, 1, 8'h3C, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 10'd5,    8'h00, 1'b1, 1'b1, 10'd1,    8'h11, 1, 8'h77, 8'hA5};
    vecs[6] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 1'b0, 10'd1,    8'h00, 1, 8'h77, 8'h11};
    post_reset = '{1'b1, 1'b0, 10'd5, 8'h00, 1'b1, 1'b0, 10'd0,    8'h00, 0, 8'h77, 8'hA5};

    ia.req = 1'b0; ia.we = 1'b0; ia.addr = '0; ia.wdata = '0;
    ib.req = 1'b0; ib.we = 1'b0; ib.addr = '0; ib.wdata = '0;
    #1 reset_p = 1'b1;
    @(negedge clk);
    checkOutput("reset_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("reset_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("reset_busy",  32'(busy),      32'd0);
    checkOutput("reset_bus",   32'(mem_data),  32'(PROBE));
    #1 reset_p = 1'b0;

    $display("[TB] directed table");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] continuous requests from both sides");
    @(negedge clk);
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = 10'd100; ia.wdata = 8'h40;
    ib.req = 1'b1; ib.we = 1'b1; ib.addr = 10'd200; ib.wdata = 8'h80;
    acks = 0;
    for (cyc = 0; cyc < 40 && acks < 4; cyc++) begin
      @(negedge clk);
      if (ia.ack || ib.ack) begin
        owners[acks] = ib.ack ? 1 : 0;
        cycles[acks] = cyc;
        acks++;
        if (ia.ack) begin
          if (acks <= 2) begin ia.addr = ia.addr + 10'd1; ia.wdata = ia.wdata + 8'd1; end
          else ia.req = 1'b0;
        end else begin
          if (acks <= 2) begin ib.addr = ib.addr + 10'd1; ib.wdata = ib.wdata + 8'd1; end
          else ib.req = 1'b0;
        end
      end
    end
    ia.req = 1'b0; ib.req = 1'b0;
    checkOutput("alt_ack_count", 32'(acks), 32'd4);
    last_cyc = cycles[0];
    for (int i = 0; i < 4 && i < acks; i++) begin
      checkOutput("alt_owner", 32'(owners[i]), 32'(i % 2));
      if (i > 0) begin
        checkOutput("alt_spacing", 32'(cycles[i] - last_cyc), 32'd3);
        last_cyc = cycles[i];
      end
    end
    repeat (4) @(negedge clk);

    $display("[TB] reset during a write access");
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = 10'd5; ia.wdata = 8'hFF;
    @(negedge clk);
    checkOutput("mid_wr_en_before", 32'(mem_wr_en), 32'd1);
    #1 reset_p = 1'b1;
    #1;
    checkOutput("mid_wr_en_after", 32'(mem_wr_en), 32'd0);
    checkOutput("mid_ack_a",       32'(ia.ack),    32'd0);
    checkOutput("mid_busy",        32'(busy),      32'd0);
    ia.req = 1'b0;
    @(negedge clk);
    #1 reset_p = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(post_reset);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (ia.req && ia.ack) begin
        if ($urandom_range(1, 0) == 1) begin
          ia.we = 1'($urandom_range(1, 0)); ia.addr = pickAddr(); ia.wdata = 8'($urandom);
        end else ia.req = 1'b0;
      end else if (!ia.req && $urandom_range(99, 0) < 35) begin
        ia.req = 1'b1; ia.we = 1'($urandom_range(1, 0)); ia.addr = pickAddr(); ia.wdata = 8'($urandom);
      end
      if (ib.req && ib.ack) begin
        if ($urandom_range(1, 0) == 1) begin
          ib.we = 1'($urandom_range(1, 0)); ib.addr = pickAddr(); ib.wdata = 8'($urandom);
        end else ib.req = 1'b0;
      end else if (!ib.req && $urandom_range(99, 0) < 35) begin
        ib.req = 1'b1; ib.we = 1'($urandom_range(1, 0)); ib.addr = pickAddr(); ib.wdata = 8'($urandom);
      end
    end
    @(negedge clk);
    ia.req = 1'b0; ib.req = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

endmodule
